dm_latency_responder: RTL
=========================

# dm_latency_responder

Data-memory responder for the pipelined CPU. It is the memory end of the CPU's `Mem_r`/`Mem_w` load/store interface. The block serves one word-aligned load or store per request after a programmable number of wait cycles. While a request is in flight it asserts `Mem_stall` to freeze the pipeline, then pulses `Mem_done` for exactly one cycle. It replaces the zero-latency data memory so the pipeline can be exercised against a slow memory.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words in the array. Power of two, 4..4096.
- `LATENCY`, 2: wait cycles between request capture and the access. Range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `Mem_r`  in  1  load request. Held by the CPU until `Mem_done`.
- `Mem_w`  in  1  store request. Held by the CPU until `Mem_done`.
- `Mem_addr`  in  32  byte address. Held stable with the request.
- `Mem_w_data`  in  32  store data. Held stable with the request.
- `Mem_r_data`  out  32  load data, registered.
- `Mem_stall`  out  1  pipeline freeze; combinational in IDLE.
- `Mem_done`  out  1  one-cycle completion pulse, registered.
- `Mem_err`  out  1  error flag, valid only while `Mem_done`=1.

## Operation
- **FSM states:**
  - IDLE to WAIT when a request is seen and `LATENCY`>0.
  - IDLE to DONE when a request is seen and `LATENCY`=0. The access is performed on that edge.
  - WAIT to WAIT while `cnt`>1; `cnt` decrements each cycle.
  - WAIT to DONE when `cnt`=1. The access is performed on that edge.
  - DONE to IDLE unconditionally.
- **Capture:** on the IDLE edge where `Mem_r|Mem_w`=1, latch op, address and write data, and set `cnt`=`LATENCY`. Inputs are ignored after capture. A request withdrawn during WAIT still completes the captured access.
- **Word index:** `Mem_addr[31:2]`.
- **Error cases:** `Mem_err`=1 if any of these holds:
  - `Mem_addr[1:0]`≠0;
  - the word index is ≥ `DEPTH`;
  - `Mem_r` and `Mem_w` are both 1 at capture.
- **Effect of an error:** no array write, `Mem_r_data` is loaded with 0, and `Mem_done` still pulses.
- **Store:** writes the full word. `Mem_r_data` is unchanged.
- **Load:** loads `Mem_r_data` from the array. The value is held until the next completed load or until reset.
- **`Mem_stall`:** equals `(IDLE & (Mem_r|Mem_w)) | WAIT`. It is 0 in DONE.
- **Requests in DONE:** the request still visible in DONE belongs to the completed access and is not re-captured. A new request is accepted at the earliest in the IDLE cycle that follows.

## Timing
- **Cycle numbering:** a request first visible in cycle 0 (IDLE) produces `Mem_stall`=1 in cycles 0..`LATENCY` and `Mem_done`=1 in cycle `LATENCY`+1.
- **Load data:** `Mem_r_data` is valid in cycle `LATENCY`+1 and later.
- **Throughput:** with a continuously held back-to-back stream, one access every `LATENCY`+2 cycles.
- **`LATENCY`=0:** `Mem_stall`=1 in cycle 0 only, and `Mem_done`=1 in cycle 1.
- **Reset values:** while `rst_n`=0, state is IDLE and `cnt`=0, and every output is 0, including `Mem_stall`.
- **Reset during WAIT:** the captured access is abandoned and nothing is written.
- **Array contents:** not reset; retained across `rst_n`. The bench initialises the array by stores.
- **Reset release:** the first request is accepted on the first rising edge with `rst_n`=1.

## Test plan
1. **Basic store then load (`LATENCY`=2):**
   - Store `0x0000_0010` ← `0xDEAD_BEEF` → `Mem_stall`=1 in cycles 0–2 and `Mem_done` in cycle 3.
   - Then load `0x10` → `Mem_r_data`=`0xDEAD_BEEF` in cycle 3 of that request, `Mem_err`=0.
2. **`LATENCY`=0, alternating store/load at addresses `0x0`, `0x4`, `0x8`:** each completes in 2 cycles, and each loaded value matches its store.
3. **Error cases:**
   - Load from `0x0000_0006` → `Mem_err`=1 with `Mem_done` and `Mem_r_data`=0.
   - Store to word index `DEPTH` → `Mem_err`=1, and a later load of word 0 is unchanged.
   - `Mem_r`=`Mem_w`=1 → `Mem_err`=1 and no write.
4. **Withdrawn request:** store `0x20` ← `0x1234_5678`, drop `Mem_w` in cycle 1 → `Mem_done` still in cycle 3, and a later load of `0x20` returns `0x1234_5678`.
5. **Reset in WAIT:** store `0x30` ← `0xFFFF_FFFF` with `rst_n` pulsed low in cycle 1 → all outputs 0 immediately and no `Mem_done`. A later load of `0x30` returns the prior contents, and a new request is served normally.
6. **Held load:** hold load `0x40` for 8 cycles (`LATENCY`=2) → exactly two `Mem_done` pulses, in cycles 3 and 7, and `Mem_stall`=0 in cycles 3 and 7.

Source files
------------

// File: rtl/dm_latency_responder.sv
// Data-memory responder with a programmable wait before each word access.
// Holds Mem_stall while a request is in flight, then pulses Mem_done for one cycle.
module dm_latency_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_r,
  input  logic        Mem_w,
  input  logic [31:0] Mem_addr,
  input  logic [31:0] Mem_w_data,
  output logic [31:0] Mem_r_data,
  output logic        Mem_stall,
  output logic        Mem_done,
  output logic        Mem_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            cap_rd_q, cap_wr_q, cap_err_q;
  logic [AW-1:0]   cap_idx_q;
  logic [31:0]     cap_wdata_q;
  logic            done_q, err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic            req, in_err, capture, access, mem_we;
  logic            acc_rd, acc_wr, acc_err;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;

  always_comb begin
    req       = Mem_r | Mem_w;
    in_err    = (Mem_addr[1:0] != 2'b00) | (|Mem_addr[31:AW+2]) | (Mem_r & Mem_w);
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    access    = 1'b0;
    acc_rd    = cap_rd_q;
    acc_wr    = cap_wr_q;
    acc_err   = cap_err_q;
    acc_idx   = cap_idx_q;
    acc_wdata = cap_wdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            // Zero wait: the access uses the live inputs on the capture edge.
            state_d   = StDone;
            access    = 1'b1;
            acc_rd    = Mem_r;
            acc_wr    = Mem_w;
            acc_err   = in_err;
            acc_idx   = Mem_addr[AW+1:2];
            acc_wdata = Mem_w_data;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      StWait: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = 4'd0;
          state_d = StDone;
          access  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Nothing may be accepted or written while reset is held.
    if (!rst_n) begin
      capture = 1'b0;
      access  = 1'b0;
    end
    mem_we    = access & acc_wr & ~acc_err;
    Mem_stall = rst_n & (((state_q == StIdle) & req) | (state_q == StWait));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      cap_rd_q    <= 1'b0;
      cap_wr_q    <= 1'b0;
      cap_err_q   <= 1'b0;
      cap_idx_q   <= '0;
      cap_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        cap_rd_q    <= Mem_r;
        cap_wr_q    <= Mem_w;
        cap_err_q   <= in_err;
        cap_idx_q   <= Mem_addr[AW+1:2];
        cap_wdata_q <= Mem_w_data;
      end
      done_q <= access;
      err_q  <= access & acc_err;
      if (access & acc_err) begin
        rdata_q <= 32'd0;
      end else if (access & acc_rd & ~acc_wr) begin
        rdata_q <= mem_q[acc_idx];
      end
    end
  end

  // Array is intentionally not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign Mem_r_data = rdata_q;
  assign Mem_done   = done_q;
  assign Mem_err    = err_q;

endmodule
